xfidb_responder: RTL and testbench
==================================

# xfidb_responder

External-side target for CPU data transfers on the 16-bit XFIDB bus, sitting opposite the CPU's bidirectional bus driver. It accepts a four-phase REQ/ACK cycle, inserts programmable wait states, and either captures write data from the bus into a 16-word register file or drives read data onto the bus. It serves as the bench/system-level counterpart that exercises the CPU driver in both directions.

## Interface
- Parameters: none.
- sysclk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  synchronous, active-high reset
- REQ  in  1  CPU bus cycle request, level, held until ACK seen
- WRITE  in  1  1 = CPU writes (CPU drives bus), 0 = CPU reads
- ADDR_3_0  in  4  register-file word select
- WAIT_3_0  in  4  number of wait states inserted (0-15)
- XFIDB_15_0_IN  in  16  bus data as driven by the CPU driver
- XFIDB_15_0_OUT  out  16  read data driven by responder
- XFIDB_OE  out  1  responder drives bus; only ever high on read cycles
- ACK  out  1  one-cycle completion pulse
- BUSY  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WAIT, XFER, ACK, HOLD.
- IDLE: on REQ=1, latch WRITE, ADDR_3_0, and WAIT_3_0 into the counter. Go to WAIT.
- WAIT: if REQ=0, abort to IDLE with no access and no ACK. Else if count==0, go to XFER; otherwise decrement.
- Entering XFER on a read: load regfile[addr] into the XFIDB_15_0_OUT register.
- XFER: XFIDB_OE=1 on reads. On writes, regfile[addr] <= XFIDB_15_0_IN on the edge leaving XFER. XFER always proceeds to ACK, even if REQ drops.
- ACK: ACK=1, and XFIDB_OE stays 1 on reads. Next state is HOLD if REQ=1, else IDLE.
- HOLD: wait for REQ=0, then go to IDLE. A new cycle requires REQ low for at least one sampled edge.
- XFIDB_OE is 0 on all write cycles. XFIDB_15_0_OUT holds its last read value when OE=0.
- Register file: 16 x 16 bits, all words cleared by reset.
- Reset values: state IDLE, counter 0, ACK 0, XFIDB_OE 0, XFIDB_15_0_OUT 16'h0000, BUSY 0, all regfile words 0.
- Reset mid-cycle: the write is not performed, ACK is not pulsed, and OE drops on the next edge.

## Timing
- Edge e0 samples REQ=1 in IDLE and enters WAIT.
- Edges e1..eN decrement the counter; edge eN+1 enters XFER; edge eN+2 enters ACK.
- ACK is high for exactly one cycle, after edge N+2.
- Read data is valid on XFIDB_15_0_OUT from edge N+1 through the ACK cycle.
- WAIT_3_0=0: XFER is entered at e1 and ACK is high after e2.
- WAIT_3_0=15: ACK is high after e17.
- Write data is sampled at edge N+2; XFIDB_15_0_IN must be stable during XFER.
- Read-after-write to the same address in back-to-back cycles returns the new data.
- WAIT_3_0, WRITE and ADDR_3_0 changes after e0 have no effect on the current cycle.

## Configuration
- XFIDB_PARITY_EN defined adds three ports:
  - PAR_IN (in, 1): odd parity accompanying write data.
  - PAR_OUT (out, 1): odd parity of XFIDB_15_0_OUT.
  - PERR (out, 1): sticky error flag.
- Parity-error write: when ^{XFIDB_15_0_IN, PAR_IN} != 1, the regfile write is suppressed, PERR is set, and ACK still pulses normally.
- PERR clears only on sys_rst.
- XFIDB_PARITY_EN undefined: these three ports are absent, all writes commit, and there is no parity logic.

## Structure
- Package xfidb_pkg holds:
  - the state enum (IDLE, WAIT, XFER, ACK, HOLD);
  - XFIDB_W = 16, ADDR_W = 4, REG_COUNT = 16, WAIT_W = 4.
- Sub-module xfidb_regfile: 16 x 16 storage with synchronous write, combinational read, and synchronous clear on reset.
- The FSM, wait counter and output registers live in the top level.

## Test plan
- Reset: assert sys_rst for 2 cycles during a WAIT -> ACK=0, OE=0, OUT=16'h0000, BUSY=0; a subsequent read of addr 3 returns 16'h0000.
- Write then read with WAIT_3_0=0:
  - Write 16'hA55A to addr 5 -> ACK high after e2.
  - Read addr 5 -> OUT=16'hA55A with OE=1 for the XFER and ACK cycles, and ACK high after e2.
- Wait states: WAIT_3_0=15 on a read of addr 0 -> ACK high exactly after edge 17 and BUSY high for 18 cycles. Varying WAIT_3_0 to 0 mid-cycle has no effect.
- Abort: REQ dropped after e3 of a WAIT_3_0=7 write of 16'h1234 to addr 2 -> return to IDLE, no ACK, addr 2 unchanged.
- Handshake: REQ held high 5 cycles after ACK -> FSM stays in HOLD, no second ACK; REQ low for 1 cycle then high -> a new cycle starts.
- Parity (XFIDB_PARITY_EN defined): write 16'h0001 with PAR_IN=1 -> PERR=1, ACK pulses, addr unchanged. Write with PAR_IN=0 -> the word commits and PERR stays 1 until reset.

Source files
------------

// File: rtl/xfidb_pkg.sv
// Shared types and sizes for the XFIDB bus responder.
package xfidb_pkg;

  localparam int XFIDB_W   = 16;
  localparam int ADDR_W    = 4;
  localparam int REG_COUNT = 16;
  localparam int WAIT_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_XFER = 3'd2,
    ST_ACK  = 3'd3,
    ST_HOLD = 3'd4
  } state_e;

  // Odd parity bit: makes the total number of ones across {data, bit} odd.
  function automatic logic odd_par(input logic [XFIDB_W-1:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/xfidb_if.sv
// XFIDB handshake/data bus bundle; the parity sideband exists only when XFIDB_PARITY_EN is defined.
interface xfidb_if;

  logic                         REQ;
  logic                         WRITE;
  logic [xfidb_pkg::ADDR_W-1:0]  ADDR_3_0;
  logic [xfidb_pkg::WAIT_W-1:0]  WAIT_3_0;
  logic [xfidb_pkg::XFIDB_W-1:0] XFIDB_15_0_IN;
  logic [xfidb_pkg::XFIDB_W-1:0] XFIDB_15_0_OUT;
  logic                         XFIDB_OE;
  logic                         ACK;
  logic                         BUSY;
`ifdef XFIDB_PARITY_EN
  logic                         PAR_IN;
  logic                         PAR_OUT;
  logic                         PERR;
`endif

  modport master (
`ifdef XFIDB_PARITY_EN
    output PAR_IN,
    input  PAR_OUT, PERR,
`endif
    output REQ, WRITE, ADDR_3_0, WAIT_3_0, XFIDB_15_0_IN,
    input  XFIDB_15_0_OUT, XFIDB_OE, ACK, BUSY
  );

  modport slave (
`ifdef XFIDB_PARITY_EN
    input  PAR_IN,
    output PAR_OUT, PERR,
`endif
    input  REQ, WRITE, ADDR_3_0, WAIT_3_0, XFIDB_15_0_IN,
    output XFIDB_15_0_OUT, XFIDB_OE, ACK, BUSY
  );

endinterface

// File: rtl/xfidb_regfile.sv
// 16 x 16 register file: synchronous write, combinational read, synchronous clear.
module xfidb_regfile
  import xfidb_pkg::*;
(
  input  logic               sysclk,
  input  logic               sys_rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [XFIDB_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [XFIDB_W-1:0] rdata
);

  logic [XFIDB_W-1:0] mem [REG_COUNT];

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/xfidb_responder.sv
// XFIDB bus target: four-phase REQ/ACK with programmable wait states into a 16-word register file.
// Optional odd-parity checking on write data is enabled by defining XFIDB_PARITY_EN.
//
//   state | meaning
//   IDLE  | no cycle; waiting for REQ
//   WAIT  | counting down wait states; REQ drop aborts
//   XFER  | access: read data presented, write data captured on exit
//   ACK   | one-cycle completion pulse
//   HOLD  | ACK given, waiting for REQ to return low
module xfidb_responder
  import xfidb_pkg::*;
(
  input  logic   sysclk,
  input  logic   sys_rst,
  xfidb_if.slave bus
);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_WAIT = ST_WAIT;
  localparam logic [2:0] S_XFER = ST_XFER;
  localparam logic [2:0] S_ACK  = ST_ACK;
  localparam logic [2:0] S_HOLD = ST_HOLD;

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WAIT_W-1:0]  cnt_q;
  logic [XFIDB_W-1:0] rdata_q;
  logic [XFIDB_W-1:0] rf_rdata;
  logic               rf_we;
  logic               wr_commit_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.REQ) state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.REQ)           state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_XFER;
      end
      S_XFER: state_d = S_ACK;
      S_ACK:  state_d = bus.REQ ? S_HOLD : S_IDLE;
      S_HOLD: if (!bus.REQ) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.REQ) begin
        wr_q   <= bus.WRITE;
        addr_q <= bus.ADDR_3_0;
        cnt_q  <= bus.WAIT_3_0;
      end
      if (state_q == S_WAIT && bus.REQ && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Read data is registered on entry to XFER and held until the next read.
      if (state_q == S_WAIT && state_d == S_XFER && !wr_q) begin
        rdata_q <= rf_rdata;
      end
    end
  end

`ifdef XFIDB_PARITY_EN
  logic perr_q;

  assign wr_commit_ok = ^{bus.XFIDB_15_0_IN, bus.PAR_IN};

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      perr_q <= 1'b0;
    end else if (state_q == S_XFER && wr_q && !wr_commit_ok) begin
      perr_q <= 1'b1;
    end
  end

  assign bus.PERR    = perr_q;
  assign bus.PAR_OUT = odd_par(rdata_q);
`else
  assign wr_commit_ok = 1'b1;
`endif

  // Writes commit on the edge leaving XFER; a reset on that edge wins inside the regfile.
  assign rf_we = (state_q == S_XFER) && wr_q && wr_commit_ok;

  xfidb_regfile u_regfile (
    .sysclk (sysclk),
    .sys_rst(sys_rst),
    .we     (rf_we),
    .waddr  (addr_q),
    .wdata  (bus.XFIDB_15_0_IN),
    .raddr  (addr_q),
    .rdata  (rf_rdata)
  );

  assign bus.XFIDB_15_0_OUT = rdata_q;
  assign bus.XFIDB_OE       = !wr_q && (state_q == S_XFER || state_q == S_ACK);
  assign bus.ACK            = (state_q == S_ACK);
  assign bus.BUSY           = (state_q != S_IDLE);

endmodule

// File: tb/tb_xfidb_responder.sv
// Self-checking bench for xfidb_responder: vector table, directed corner cases, random traffic vs. a behavioural model.
module tb_xfidb_responder;
  import xfidb_pkg::*;

  logic sysclk = 1'b0;
  logic sys_rst;
  always #5 sysclk = ~sysclk;

  xfidb_if bus();

  xfidb_responder dut (
    .sysclk (sysclk),
    .sys_rst(sys_rst),
    .bus    (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: register contents, last read value, sticky parity error.
  logic [15:0] mem [16];
  logic [15:0] last_rd;
  logic        perr_exp;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [3:0]  wt;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    last_rd  = 16'h0000;
    perr_exp = 1'b0;
  endtask

  task automatic set_par(input logic [15:0] d, input logic bad);
`ifdef XFIDB_PARITY_EN
    bus.PAR_IN = bad ? (^d) : ~(^d);
`else
    if (bad) $display("note: parity injection ignored in this build");
`endif
  endtask

  // One complete bus cycle. Timing expectations come straight from the cycle rules:
  // ACK after edge wt+2, OE on reads after edges wt+1 and wt+2, BUSY for wt+3 cycles.
  task automatic xact(input logic wr, input logic [3:0] a, input logic [3:0] wt,
                      input logic [15:0] d, input int hold, input logic bad_par,
                      output logic [15:0] rd);
    int   ack_edge = -1;
    int   ack_cnt  = 0;
    int   busy_cnt = 0;
    logic oe_ok    = 1'b1;
    logic data_ok  = 1'b1;
    logic exp_oe;
    rd = 16'hxxxx;
    bus.REQ = 1'b1;
    bus.WRITE = wr;
    bus.ADDR_3_0 = a;
    bus.WAIT_3_0 = wt;
    bus.XFIDB_15_0_IN = d;
    set_par(d, bad_par);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 0) begin
        // Control inputs after e0 must be ignored.
        bus.WAIT_3_0 = 4'd0;
        bus.ADDR_3_0 = 4'($urandom);
        bus.WRITE    = ~wr;
      end
      if (bus.BUSY === 1'b1) busy_cnt++;
      exp_oe = !wr && (k == int'(wt) + 1 || k == int'(wt) + 2);
      if (bus.XFIDB_OE !== exp_oe) oe_ok = 1'b0;
      if (!wr && k == int'(wt) + 1 && bus.XFIDB_15_0_OUT !== mem[a]) data_ok = 1'b0;
      if (bus.ACK === 1'b1) begin
        ack_cnt++;
        ack_edge = k;
        rd = bus.XFIDB_15_0_OUT;
        break;
      end
    end
    chk("ack_edge", ack_edge, int'(wt) + 2);
    chk("busy_cycles", busy_cnt, int'(wt) + 3);
    if (ack_edge >= 0) begin
      if (wr) begin
        if (bad_par) perr_exp = 1'b1;
        else         mem[a] = d;
      end else begin
        chk("read_data", rd, mem[a]);
        chk("xfer_data", data_ok, 1'b1);
        last_rd = mem[a];
      end
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      if (bus.ACK === 1'b1) ack_cnt++;
      if (bus.BUSY !== 1'b1) busy_cnt = -100;
      if (bus.XFIDB_OE !== 1'b0) oe_ok = 1'b0;
    end
    if (hold > 0) chk("hold_busy", busy_cnt, int'(wt) + 3);
    bus.REQ = 1'b0;
    tick();
    chk("ack_once", ack_cnt, 1);
    chk("oe_pattern", oe_ok, 1'b1);
    chk("idle_busy", bus.BUSY, 1'b0);
    chk("out_hold", bus.XFIDB_15_0_OUT, last_rd);
`ifdef XFIDB_PARITY_EN
    chk("perr", bus.PERR, perr_exp);
    chk("par_out", bus.PAR_OUT, ~(^last_rd));
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},  bus.ACK, 1'b0);
    chk({tag, "_oe"},   bus.XFIDB_OE, 1'b0);
    chk({tag, "_out"},  bus.XFIDB_15_0_OUT, 16'h0000);
    chk({tag, "_busy"}, bus.BUSY, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        ack_seen;

    bus.REQ = 1'b0;
    bus.WRITE = 1'b0;
    bus.ADDR_3_0 = 4'd0;
    bus.WAIT_3_0 = 4'd0;
    bus.XFIDB_15_0_IN = 16'h0000;
    set_par(16'h0000, 1'b0);
    sys_rst = 1'b1;
    model_reset();
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    chk_reset_outputs("por");

    vecs[0] = '{wr: 1'b1, addr: 4'd5,  wt: 4'd0,  data: 16'hA55A, exp: 16'h0000};
    vecs[1] = '{wr: 1'b0, addr: 4'd5,  wt: 4'd0,  data: 16'h0000, exp: 16'hA55A};
    vecs[2] = '{wr: 1'b1, addr: 4'd2,  wt: 4'd3,  data: 16'h1234, exp: 16'h0000};
    vecs[3] = '{wr: 1'b0, addr: 4'd2,  wt: 4'd9,  data: 16'hFFFF, exp: 16'h1234};
    vecs[4] = '{wr: 1'b0, addr: 4'd3,  wt: 4'd1,  data: 16'h0000, exp: 16'h0000};
    vecs[5] = '{wr: 1'b0, addr: 4'd0,  wt: 4'd15, data: 16'h0000, exp: 16'h0000};
    vecs[6] = '{wr: 1'b1, addr: 4'd5,  wt: 4'd2,  data: 16'hBEEF, exp: 16'h0000};
    vecs[7] = '{wr: 1'b0, addr: 4'd5,  wt: 4'd0,  data: 16'h0000, exp: 16'hBEEF};

    for (int i = 0; i < 8; i++) begin
      xact(vecs[i].wr, vecs[i].addr, vecs[i].wt, vecs[i].data, 0, 1'b0, rd);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end

    // Reset during a read XFER: OE and OUT drop on the next edge.
    bus.REQ = 1'b1; bus.WRITE = 1'b0; bus.ADDR_3_0 = 4'd5; bus.WAIT_3_0 = 4'd0;
    tick();
    tick();
    chk("xfer_oe", bus.XFIDB_OE, 1'b1);
    chk("xfer_out", bus.XFIDB_15_0_OUT, 16'hBEEF);
    sys_rst = 1'b1;
    tick();
    chk_reset_outputs("rst_xfer");
    tick();
    sys_rst = 1'b0; bus.REQ = 1'b0;
    model_reset();
    tick();

    // Reset held two cycles during WAIT wipes the register file.
    xact(1'b1, 4'd3, 4'd0, 16'h3333, 0, 1'b0, rd);
    bus.REQ = 1'b1; bus.WRITE = 1'b0; bus.ADDR_3_0 = 4'd3; bus.WAIT_3_0 = 4'd7;
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    tick();
    chk_reset_outputs("rst_wait");
    sys_rst = 1'b0; bus.REQ = 1'b0;
    model_reset();
    tick();
    xact(1'b0, 4'd3, 4'd0, 16'h0000, 0, 1'b0, rd);
    chk("rst_clears_rf", rd, 16'h0000);

    // Abort: REQ dropped after e3 of a 7-wait write.
    bus.REQ = 1'b1; bus.WRITE = 1'b1; bus.ADDR_3_0 = 4'd2; bus.WAIT_3_0 = 4'd7;
    bus.XFIDB_15_0_IN = 16'h1234;
    set_par(16'h1234, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    bus.REQ = 1'b0;
    ack_seen = 1'b0;
    tick();
    chk("abort_idle", bus.BUSY, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (bus.ACK === 1'b1) ack_seen = 1'b1;
      tick();
    end
    chk("abort_no_ack", ack_seen, 1'b0);
    xact(1'b0, 4'd2, 4'd0, 16'h0000, 0, 1'b0, rd);
    chk("abort_unchanged", rd, 16'h0000);

    // REQ held 5 cycles past ACK, then one low cycle, then back-to-back read-after-write.
    xact(1'b1, 4'd9, 4'd1, 16'h5A5A, 5, 1'b0, rd);
    xact(1'b0, 4'd9, 4'd0, 16'h0000, 0, 1'b0, rd);
    chk("raw_same_addr", rd, 16'h5A5A);

`ifdef XFIDB_PARITY_EN
    xact(1'b1, 4'd6, 4'd0, 16'h0001, 0, 1'b1, rd);
    chk("perr_set", bus.PERR, 1'b1);
    xact(1'b0, 4'd6, 4'd0, 16'h0000, 0, 1'b0, rd);
    chk("perr_suppressed", rd, 16'h0000);
    xact(1'b1, 4'd6, 4'd0, 16'h0001, 0, 1'b0, rd);
    xact(1'b0, 4'd6, 4'd0, 16'h0000, 0, 1'b0, rd);
    chk("par_commit", rd, 16'h0001);
    chk("perr_sticky", bus.PERR, 1'b1);
`endif

    for (int n = 0; n < 60; n++) begin
      logic        wr;
      logic        bad;
      wr  = 1'($urandom_range(0, 1));
`ifdef XFIDB_PARITY_EN
      bad = wr && ($urandom_range(0, 3) == 0);
`else
      bad = 1'b0;
`endif
      xact(wr, 4'($urandom), 4'($urandom_range(0, 15)), 16'($urandom),
           $urandom_range(0, 2), bad, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
